// File: rtl/triangle_setup.sv
// Triangle setup: assembles x/y/z/w component streams into triangles, maps them to screen space,
// computes doubled area and clipped bbox, and buffers results. Optional macro: TRIANGLE_SETUP_CULL_EN.
module triangle_setup #(
  parameter int unsigned M     = 11,
  parameter int unsigned H_RES = 800,
  parameter int unsigned V_RES = 600
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [M-1:0]   input_vertex,
  input  logic                  input_vertex_valid,
  output logic signed [M:0]     tri_x0,
  output logic signed [M:0]     tri_y0,
  output logic signed [M:0]     tri_x1,
  output logic signed [M:0]     tri_y1,
  output logic signed [M:0]     tri_x2,
  output logic signed [M:0]     tri_y2,
  output logic signed [2*M+3:0] tri_area,
  output logic [9:0]            bbox_xmin,
  output logic [9:0]            bbox_xmax,
  output logic [9:0]            bbox_ymin,
  output logic [9:0]            bbox_ymax,
  output logic                  tri_valid,
  input  logic                  tri_ready,
  output logic                  overflow
);

  localparam int unsigned CW = M + 1;
  localparam int unsigned AW = 2 * M + 4;
  localparam int unsigned BW = 10;

  localparam logic signed [CW-1:0] HalfH = CW'(H_RES / 2);
  localparam logic signed [CW-1:0] HalfV = CW'(V_RES / 2);
  localparam logic signed [CW-1:0] XHi   = CW'(H_RES - 1);
  localparam logic signed [CW-1:0] YHi   = CW'(V_RES - 1);

  typedef enum logic [1:0] {StCollect, StArea, StBbox, StPush} state_e;

  typedef struct packed {
    logic signed [CW-1:0] sx0;
    logic signed [CW-1:0] sy0;
    logic signed [CW-1:0] sx1;
    logic signed [CW-1:0] sy1;
    logic signed [CW-1:0] sx2;
    logic signed [CW-1:0] sy2;
    logic signed [AW-1:0] area;
    logic [BW-1:0]        xmin;
    logic [BW-1:0]        xmax;
    logic [BW-1:0]        ymin;
    logic [BW-1:0]        ymax;
  } entry_t;

  function automatic logic signed [CW-1:0] min3(input logic signed [CW-1:0] a,
                                                input logic signed [CW-1:0] b,
                                                input logic signed [CW-1:0] c);
    logic signed [CW-1:0] m;
    m = (b < a) ? b : a;
    m = (c < m) ? c : m;
    return m;
  endfunction

  function automatic logic signed [CW-1:0] max3(input logic signed [CW-1:0] a,
                                                input logic signed [CW-1:0] b,
                                                input logic signed [CW-1:0] c);
    logic signed [CW-1:0] m;
    m = (b > a) ? b : a;
    m = (c > m) ? c : m;
    return m;
  endfunction

  function automatic logic [BW-1:0] clamp(input logic signed [CW-1:0] v,
                                          input logic signed [CW-1:0] hi);
    logic [BW-1:0] r;
    if (v[CW-1]) begin
      r = '0;
    end else if (v > hi) begin
      r = hi[BW-1:0];
    end else begin
      r = v[BW-1:0];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Component collection
  // ---------------------------------------------------------------------------
  logic [1:0]         comp_q, comp_d;
  logic [1:0]         vtx_q, vtx_d;
  logic signed [M-1:0] cx_q [3];
  logic signed [M-1:0] cy_q [3];
  logic               tri_done;

  assign tri_done = input_vertex_valid && (comp_q == 2'd3) && (vtx_q == 2'd2);

  // Any idle cycle drops a partial triangle; with both counters at zero this is a no-op.
  always_comb begin
    comp_d = comp_q;
    vtx_d  = vtx_q;
    if (!input_vertex_valid) begin
      comp_d = 2'd0;
      vtx_d  = 2'd0;
    end else begin
      comp_d = comp_q + 2'd1;
      if (comp_q == 2'd3) begin
        vtx_d = (vtx_q == 2'd2) ? 2'd0 : vtx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      comp_q <= 2'd0;
      vtx_q  <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        cx_q[i] <= '0;
        cy_q[i] <= '0;
      end
    end else begin
      comp_q <= comp_d;
      vtx_q  <= vtx_d;
      if (input_vertex_valid && (comp_q == 2'd0)) cx_q[vtx_q] <= input_vertex;
      if (input_vertex_valid && (comp_q == 2'd1)) cy_q[vtx_q] <= input_vertex;
    end
  end

  // ---------------------------------------------------------------------------
  // Setup pipeline
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic signed [M-1:0]  mx_q [3];
  logic signed [M-1:0]  my_q [3];
  logic signed [CW-1:0] sx_q [3];
  logic signed [CW-1:0] sy_q [3];
  logic signed [AW-1:0] area_q;
  logic [BW-1:0]        xmin_q, xmax_q, ymin_q, ymax_q;

  logic signed [CW-1:0]   ex [3];
  logic signed [CW-1:0]   ey [3];
  logic signed [CW-1:0]   sx_c [3];
  logic signed [CW-1:0]   sy_c [3];
  logic signed [CW-1:0]   dx1, dy1, dx2, dy2;
  logic signed [2*CW-1:0] p0, p1;
  logic signed [AW-1:0]   area_c;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ex[i]   = {mx_q[i][M-1], mx_q[i]};
      ey[i]   = {my_q[i][M-1], my_q[i]};
      sx_c[i] = ex[i] + HalfH;
      sy_c[i] = HalfV - ey[i];
    end
    dx1    = ex[1] - ex[0];
    dy1    = ey[1] - ey[0];
    dx2    = ex[2] - ex[0];
    dy2    = ey[2] - ey[0];
    p0     = dx1 * dy2;
    p1     = dx2 * dy1;
    area_c = $signed({{(AW-2*CW){p0[2*CW-1]}}, p0}) - $signed({{(AW-2*CW){p1[2*CW-1]}}, p1});
  end

  logic signed [CW-1:0] xlo, xhi, ylo, yhi;
  logic                 offscreen;
  logic                 cull;

  assign xlo = min3(sx_q[0], sx_q[1], sx_q[2]);
  assign xhi = max3(sx_q[0], sx_q[1], sx_q[2]);
  assign ylo = min3(sy_q[0], sy_q[1], sy_q[2]);
  assign yhi = max3(sy_q[0], sy_q[1], sy_q[2]);

  assign offscreen = xhi[CW-1] || (xlo > XHi) || yhi[CW-1] || (ylo > YHi);

`ifdef TRIANGLE_SETUP_CULL_EN
  // Clockwise and degenerate triangles never reach the buffer.
  assign cull = area_q[AW-1] || (area_q == '0);
`else
  assign cull = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StCollect: if (tri_done) state_d = StArea;
      StArea:    state_d = StBbox;
      StBbox:    state_d = (offscreen || cull) ? StCollect : StPush;
      StPush:    state_d = StCollect;
      default:   state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StCollect;
      area_q  <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        mx_q[i] <= '0;
        my_q[i] <= '0;
        sx_q[i] <= '0;
        sy_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if ((state_q == StCollect) && tri_done) begin
        // Vertex 2 x/y were captured earlier in this triangle, so cx_q/cy_q are complete.
        for (int i = 0; i < 3; i++) begin
          mx_q[i] <= cx_q[i];
          my_q[i] <= cy_q[i];
        end
      end
      if (state_q == StArea) begin
        area_q <= area_c;
        for (int i = 0; i < 3; i++) begin
          sx_q[i] <= sx_c[i];
          sy_q[i] <= sy_c[i];
        end
      end
      if (state_q == StBbox) begin
        xmin_q <= clamp(xlo, XHi);
        xmax_q <= clamp(xhi, XHi);
        ymin_q <= clamp(ylo, YHi);
        ymax_q <= clamp(yhi, YHi);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Two-entry output buffer
  // ---------------------------------------------------------------------------
  entry_t     fifo_q [2];
  entry_t     new_entry;
  entry_t     head;
  logic       wr_q, rd_q;
  logic [1:0] cnt_q, cnt_d;
  logic       overflow_q;
  logic       push_req, push, pop, full;

  assign new_entry = '{sx0: sx_q[0], sy0: sy_q[0], sx1: sx_q[1], sy1: sy_q[1],
                       sx2: sx_q[2], sy2: sy_q[2], area: area_q,
                       xmin: xmin_q, xmax: xmax_q, ymin: ymin_q, ymax: ymax_q};

  assign push_req = (state_q == StPush);
  assign full     = (cnt_q == 2'd2);
  assign pop      = (cnt_q != 2'd0) && tri_ready;
  assign push     = push_req && (!full || pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      cnt_q      <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        fifo_q[wr_q] <= new_entry;
        wr_q         <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      if (push_req && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign head      = fifo_q[rd_q];
  assign tri_x0    = head.sx0;
  assign tri_y0    = head.sy0;
  assign tri_x1    = head.sx1;
  assign tri_y1    = head.sy1;
  assign tri_x2    = head.sx2;
  assign tri_y2    = head.sy2;
  assign tri_area  = head.area;
  assign bbox_xmin = head.xmin;
  assign bbox_xmax = head.xmax;
  assign bbox_ymin = head.ymin;
  assign bbox_ymax = head.ymax;
  assign tri_valid = (cnt_q != 2'd0);
  assign overflow  = overflow_q;

endmodule

// File: doc/triangle_setup.md
# triangle_setup

Downstream stage of `vertex_processor_rtl`. Consumes its serial transformed-component stream, groups every four components into one vertex and every three vertices into one triangle, and maps model coordinates to screen coordinates. It then computes the signed doubled area and a screen-clipped bounding box, and presents each triangle on a valid/ready interface to the hardware rasterizer. A 2-entry triangle buffer absorbs rasterizer stalls, because the vertex processor cannot be back-pressured.

## Interface
Parameters:
- `M`, 11: input component width (signed), same as the vertex processor output width.
- `H_RES`, 800: screen width in pixels.
- `V_RES`, 600: screen height in pixels.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `input_vertex`  in  M  signed component, fed directly from `output_vertex`.
- `input_vertex_valid`  in  1  component strobe; no ready path exists upstream.
- `tri_x0`,`tri_y0`,`tri_x1`,`tri_y1`,`tri_x2`,`tri_y2`  out  M+1 each  signed screen coordinates.
- `tri_area`  out  2M+4  signed doubled area, computed in model coordinates.
- `bbox_xmin`,`bbox_xmax`  out  10  bounding box X limits, clipped to 0..H_RES-1.
- `bbox_ymin`,`bbox_ymax`  out  10  bounding box Y limits, clipped to 0..V_RES-1.
- `tri_valid`  out  1  buffer head holds a triangle.
- `tri_ready`  in  1  rasterizer accepts the head triangle.
- `overflow`  out  1  sticky: at least one triangle was dropped because the buffer was full.

## Operation
- Component counter `comp` runs 0..3 in the order x, y, z, w.
  - It advances on each valid cycle.
  - Only x and y are kept; z and w are discarded.
- Vertex counter `vtx` runs 0..2 and advances when `comp`=3 is accepted.
- The cycle carrying w of `vtx`=2 marks the triangle complete and starts setup.
- Screen mapping:
  - `sx = x + H_RES/2`
  - `sy = V_RES/2 - y`
  - Both are sign-extended to M+1 bits; no saturation is applied.
- Area: `(x1-x0)*(y2-y0) - (x2-x0)*(y1-y0)` on model x/y, full precision, result width 2M+4.
- Bounding box:
  - Take the min and max of `sx` and of `sy`.
  - Clamp each to `[0, H_RES-1]` (X) or `[0, V_RES-1]` (Y).
  - If the box lies entirely off-screen (e.g. xmax < 0), the triangle is dropped silently; it is not an overflow.
- Setup FSM:
  - States: `COLLECT` -> `AREA` -> `BBOX` -> `PUSH` -> `COLLECT`.
  - Collection of the next triangle continues in parallel. Setup takes 3 cycles, and a triangle arrives at most every 12 cycles, so setup never collides with the next triangle.
- Triangle buffer: 2-entry FIFO; the head drives all `tri_*` and `bbox_*` outputs.
  - Pop when `tri_valid && tri_ready`.
  - Push in `PUSH`.
  - Push and pop in the same cycle is allowed when the buffer is full.
  - If a push arrives while the buffer is full and there is no pop, the new triangle is dropped and `overflow` sets.
- Stream break: a cycle with `input_vertex_valid`=0 while `comp`≠0 or `vtx`≠0 discards the partial triangle and resets both counters to 0. Setup already in flight completes normally.

## Timing
- Reset values: `tri_valid`=0, `overflow`=0. All data outputs are 0. Counters are 0, FSM is `COLLECT`, FIFO is empty.
- Reset mid-operation: the partial triangle, in-flight setup and all buffered triangles are lost. Outputs return to reset values on the next edge.
- Latency: `tri_valid` rises 3 cycles after the rising edge that samples the final w component, with an empty buffer.
- Output data is stable while `tri_valid`=1 and `tri_ready`=0.
- `tri_valid` must not depend combinationally on `tri_ready`.
- `overflow` is cleared only by `reset`.

## Configuration
- Macro `TRIANGLE_SETUP_CULL_EN`.
- When defined: triangles with `tri_area` ≤ 0 (clockwise or degenerate) are dropped in `BBOX` and never pushed, so they cannot cause an overflow.
- When undefined: all on-screen triangles are pushed regardless of area.

## Test plan
- Vertices (0,0),(100,0),(0,100) streamed as 12 consecutive components with `tri_ready`=1:
  - `tri_valid` rises 3 cycles after the last component.
  - Screen vertices (400,300),(500,300),(400,200).
  - `tri_area`=10000.
  - Bbox X 400..500, Y 200..300.
- Vertex (-1000,0) plus (0,0),(0,-500): bbox clamps to X 0..400, Y 300..599.
- Clockwise triangle (0,0),(0,100),(100,0), giving `tri_area`=-10000:
  - Dropped with `TRIANGLE_SETUP_CULL_EN`.
  - Delivered without it.
- `tri_ready`=0 held while 3 triangles are streamed:
  - First two are buffered, third is dropped, `overflow`=1.
  - Raising `tri_ready` then delivers exactly 2 triangles in arrival order.
- Valid gap after 7 components, then 12 fresh components: exactly one triangle is output, built from the fresh components only.
- `reset` asserted for one cycle with one triangle buffered and one in setup: `tri_valid`=0 next cycle, and no triangle appears afterwards.
